// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: mode encodings, feedback taps and the checker state set.
// The generator and checker both draw their polynomial constants from here.
package prbs_pkg;

  localparam logic [1:0] MODE_PRBS7 = 2'b00;
  localparam logic [1:0] MODE_PRBS9 = 2'b01;

  // Taps as polynomial exponents; history bit index is exponent-1.
  localparam int PRBS7_TAP_A = 7;
  localparam int PRBS7_TAP_B = 6;
  localparam int PRBS9_TAP_A = 9;
  localparam int PRBS9_TAP_B = 5;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/prbs_predict.sv
// Combinational next-bit predictor for PRBS7/PRBS9 over a 9-bit history
// (hist[0] newest). Any mode other than PRBS7 selects PRBS9.
module prbs_predict
  import prbs_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [8:0] hist,
  output logic       pred
);

  logic unused_hist;

  assign pred = (mode == MODE_PRBS7) ? (hist[PRBS7_TAP_A-1] ^ hist[PRBS7_TAP_B-1])
                                     : (hist[PRBS9_TAP_A-1] ^ hist[PRBS9_TAP_B-1]);

  assign unused_hist = ^{hist[7], hist[3:0]};

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS7/PRBS9 checker: seeds from the line, verifies, locks,
// then counts bits and errors with windowed loss-of-lock detection.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 16,
  parameter int ERR_WINDOW = 64,
  parameter int ERR_THRESH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        data_in,
  input  logic        data_valid,
  input  logic        clear_counters,
  output logic        locked,
  output logic        error_pulse,
  output logic [31:0] bit_count,
  output logic [31:0] error_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(ERR_WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(ERR_WINDOW - 1);
  localparam logic [EW-1:0] THRESH     = EW'(ERR_THRESH);

  state_t        state;
  logic [1:0]    mode_q;
  logic [8:0]    s;
  logic [3:0]    fill;
  logic [MW-1:0] match;
  logic [WW-1:0] win_bits;
  logic [EW-1:0] win_errs;

  logic          pred;
  logic          err;
  logic [8:0]    s_in;
  logic [3:0]    fill_last;
  logic          seed_ok;
  logic [EW-1:0] win_errs_next;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  prbs_predict u_predict (
    .mode (mode_q),
    .hist (s),
    .pred (pred)
  );

  assign err           = data_in ^ pred;
  assign s_in          = {s[7:0], data_in};
  assign fill_last     = (mode_q == MODE_PRBS7) ? 4'd6 : 4'd8;
  // Seed check looks at the history including the bit being shifted in now.
  assign seed_ok       = (mode_q == MODE_PRBS7) ? (|s_in[6:0]) : (|s_in);
  assign win_errs_next = win_errs + EW'(err);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEED;
      mode_q      <= MODE_PRBS7;
      s           <= '0;
      fill        <= '0;
      match       <= '0;
      win_bits    <= '0;
      win_errs    <= '0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
      bit_count   <= '0;
      error_count <= '0;
    end else begin
      error_pulse <= 1'b0;
      if (mode != mode_q) begin
        mode_q   <= mode;
        state    <= SEED;
        fill     <= '0;
        match    <= '0;
        win_bits <= '0;
        win_errs <= '0;
        locked   <= 1'b0;
      end else if (data_valid) begin
        case (state)
          SEED: begin
            s <= s_in;
            if (fill == fill_last) begin
              fill <= '0;
              if (seed_ok) state <= VERIFY;
            end else begin
              fill <= fill + 4'd1;
            end
          end
          VERIFY: begin
            s <= s_in;
            if (err) begin
              state <= SEED;
              fill  <= '0;
              match <= '0;
            end else if (match == MATCH_LAST) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              match    <= '0;
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              match <= match + MW'(1);
            end
          end
          LOCKED: begin
            // Regenerate locally so a single line error never corrupts the history.
            s         <= {s[7:0], pred};
            bit_count <= sat_inc(bit_count);
            if (err) begin
              error_count <= sat_inc(error_count);
              error_pulse <= 1'b1;
            end
            if (win_errs_next >= THRESH) begin
              state    <= SEED;
              locked   <= 1'b0;
              fill     <= '0;
              win_bits <= '0;
              win_errs <= '0;
            end else if (win_bits == WIN_LAST) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + WW'(1);
              win_errs <= win_errs_next;
            end
          end
          default: state <= SEED;
        endcase
      end
      if (clear_counters) begin
        bit_count   <= '0;
        error_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised-stream bench for prbs_checker with a bit-history reference model
// compared against every output after every clock.
module tb_prbs_checker;
  import prbs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        data_in;
  logic        data_valid;
  logic        clear_counters;
  logic        locked;
  logic        error_pulse;
  logic [31:0] bit_count;
  logic [31:0] error_count;

  int n_checks = 0;
  int n_errors = 0;

  prbs_checker dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .clear_counters (clear_counters),
    .locked         (locked),
    .error_pulse    (error_pulse),
    .bit_count      (bit_count),
    .error_count    (error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the received sequence must obey b[n] = b[n-N] ^ b[n-T].
  int          m_phase;  // 0 acquiring, 1 verifying, 2 locked
  int          m_fill, m_match, m_wb, m_we;
  bit          m_hist[$];
  logic [31:0] m_bits, m_errs;
  bit          m_locked, m_pulse;
  logic [1:0]  m_mode;

  function automatic int degree(input logic [1:0] md);
    return (md == 2'b00) ? 7 : 9;
  endfunction

  function automatic int second_tap(input logic [1:0] md);
    return (md == 2'b00) ? 6 : 5;
  endfunction

  function automatic bit m_expect();
    return m_hist[m_hist.size() - degree(m_mode)] ^ m_hist[m_hist.size() - second_tap(m_mode)];
  endfunction

  task automatic m_push(input bit b);
    m_hist.push_back(b);
    if (m_hist.size() > 9) void'(m_hist.pop_front());
  endtask

  task automatic model_reset();
    m_phase = 0; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
    m_bits = 0; m_errs = 0; m_locked = 0; m_pulse = 0; m_mode = 2'b00;
    m_hist.delete();
    for (int k = 0; k < 9; k++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step(input logic [1:0] md, input bit v, input bit d, input bit clr);
    bit p, nz;
    m_pulse = 0;
    if (md !== m_mode) begin
      m_mode = md; m_phase = 0; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0; m_locked = 0;
    end else if (v) begin
      if (m_phase == 0) begin
        m_push(d);
        m_fill++;
        if (m_fill == degree(m_mode)) begin
          m_fill = 0;
          nz = 0;
          for (int k = 1; k <= degree(m_mode); k++) nz |= m_hist[m_hist.size() - k];
          if (nz) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        p = m_expect();
        m_push(d);
        if (d != p) begin
          m_phase = 0; m_fill = 0; m_match = 0;
        end else begin
          m_match++;
          if (m_match == 16) begin
            m_phase = 2; m_locked = 1; m_match = 0; m_wb = 0; m_we = 0;
          end
        end
      end else begin
        p = m_expect();
        m_push(p);
        if (m_bits != 32'hFFFF_FFFF) m_bits++;
        m_wb++;
        if (d != p) begin
          if (m_errs != 32'hFFFF_FFFF) m_errs++;
          m_pulse = 1;
          m_we++;
        end
        if (m_we >= 8) begin
          m_phase = 0; m_locked = 0; m_fill = 0; m_wb = 0; m_we = 0;
        end else if (m_wb == 64) begin
          m_wb = 0; m_we = 0;
        end
      end
    end
    if (clr) begin
      m_bits = 0; m_errs = 0;
    end
  endtask

  // Stimulus generator: a free-running PRBS sequence from a seed.
  bit g_hist[$];
  int g_deg, g_tap;

  task automatic gen_init(input logic [1:0] md, input logic [8:0] seed);
    g_hist.delete();
    g_deg = degree(md);
    g_tap = second_tap(md);
    for (int k = g_deg - 1; k >= 0; k--) g_hist.push_back(seed[k]);
  endtask

  function automatic bit gen_next();
    bit b;
    b = g_hist[g_hist.size() - g_deg] ^ g_hist[g_hist.size() - g_tap];
    g_hist.push_back(b);
    if (g_hist.size() > 9) void'(g_hist.pop_front());
    return b;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(mode, data_valid, data_in, clear_counters);
    #1;
    check("locked", {31'b0, locked}, {31'b0, m_locked});
    check("error_pulse", {31'b0, error_pulse}, {31'b0, m_pulse});
    check("bit_count", bit_count, m_bits);
    check("error_count", error_count, m_errs);
  endtask

  task automatic send_bit(input bit v, input bit d, input bit clr);
    data_valid = v;
    data_in = d;
    clear_counters = clr;
    cycle();
  endtask

  task automatic send(input bit v, input bit flip, input bit clr);
    bit d;
    d = v ? (gen_next() ^ flip) : bit'($urandom_range(0, 1));
    send_bit(v, d, clr);
  endtask

  task automatic run_until_lock(input bit toggle, input int max, output int n);
    n = 0;
    while (!locked && n < max) begin
      send(1'b1, 1'b0, 1'b0);
      n++;
      if (toggle && !locked) send(1'b0, 1'b0, 1'b0);
    end
    check("lock_reached", {31'b0, locked}, 32'd1);
  endtask

  int  n, pulses;
  bit  saw_lock;
  logic [31:0] held_bits;

  initial begin
    reset = 1'b1; mode = 2'b00; data_in = 1'b0; data_valid = 1'b0; clear_counters = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", {31'b0, locked}, 32'd0);
    check("rst_pulse", {31'b0, error_pulse}, 32'd0);
    check("rst_bits", bit_count, 32'd0);
    check("rst_errs", error_count, 32'd0);
    reset = 1'b0;

    // Clean PRBS7, continuous valid.
    gen_init(2'b00, 9'h07F);
    run_until_lock(1'b0, 60, n);
    check("prbs7_lock_bit", n, 32'd23);
    for (int i = 0; i < 1000; i++) send(1'b1, 1'b0, 1'b0);
    check("prbs7_bits", bit_count, 32'd1000);
    check("prbs7_errs", error_count, 32'd0);

    // Clean PRBS9 with data_valid toggling; mode change and clear on an idle cycle.
    mode = 2'b01;
    send(1'b0, 1'b0, 1'b1);
    check("mode_chg_unlock", {31'b0, locked}, 32'd0);
    gen_init(2'b01, 9'(($urandom % 511) + 1));
    run_until_lock(1'b1, 60, n);
    check("prbs9_lock_bit", n, 32'd25);
    held_bits = bit_count;
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 1'b0);
    check("invalid_hold", bit_count, held_bits);

    // Two isolated flips while locked.
    send(1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 1; i <= 400; i++) begin
      send(1'b1, (i == 100) || (i == 300), 1'b0);
      pulses += int'(error_pulse);
    end
    check("two_flip_pulses", pulses, 32'd2);
    check("two_flip_errs", error_count, 32'd2);
    check("two_flip_locked", {31'b0, locked}, 32'd1);

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    reset = 1'b1;
    #1;
    check("async_rst_locked", {31'b0, locked}, 32'd0);
    check("async_rst_bits", bit_count, 32'd0);
    check("async_rst_errs", error_count, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(1'b0, 1'b0, 1'b0);
    gen_init(2'b01, 9'(($urandom % 511) + 1));
    run_until_lock(1'b0, 60, n);
    check("relock_after_rst", n, 32'd25);

    // Eight flips inside one window force loss of lock on the eighth.
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1'b0);
    for (int f = 1; f <= 8; f++) begin
      send(1'b1, 1'b1, 1'b0);
      if (f == 7) check("locked_at_7", {31'b0, locked}, 32'd1);
      if (f < 8) send(1'b1, 1'b0, 1'b0);
    end
    check("drop_at_8", {31'b0, locked}, 32'd0);
    check("drop_errs", error_count, 32'd8);
    held_bits = bit_count;
    run_until_lock(1'b0, 60, n);
    check("relock_after_drop", n, 32'd25);
    check("held_errs", error_count, 32'd8);
    check("held_bits", bit_count, held_bits);

    // All-zero input never locks.
    mode = 2'b00;
    send(1'b0, 1'b0, 1'b0);
    saw_lock = 0;
    for (int i = 0; i < 50; i++) begin
      send_bit(1'b1, 1'b0, 1'b0);
      saw_lock |= locked;
    end
    check("zero_no_lock", {31'b0, saw_lock}, 32'd0);
    check("zero_state", 32'(dut.state), 32'(SEED));
    gen_init(2'b00, 9'(($urandom % 127) + 1));
    run_until_lock(1'b0, 60, n);

    // Mode switch while locked drops lock at once, then relocks to PRBS9.
    mode = 2'b01;
    send(1'b0, 1'b0, 1'b0);
    check("mode_switch_drop", {31'b0, locked}, 32'd0);
    gen_init(2'b01, 9'(($urandom % 511) + 1));
    run_until_lock(1'b0, 60, n);
    check("mode_switch_relock", n, 32'd25);

    // Saturation from a preloaded value, then clear beating a same-cycle error.
    force dut.bit_count = 32'hFFFF_FFFE;
    force dut.error_count = 32'hFFFF_FFFE;
    #1;
    release dut.bit_count;
    release dut.error_count;
    m_bits = 32'hFFFF_FFFE;
    m_errs = 32'hFFFF_FFFE;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      send(1'b1, (i == 2) || (i == 6) || (i == 10), 1'b0);
      pulses += int'(error_pulse);
    end
    check("sat_pulses", pulses, 32'd3);
    check("sat_errs", error_count, 32'hFFFF_FFFF);
    check("sat_bits", bit_count, 32'hFFFF_FFFF);
    send(1'b1, 1'b1, 1'b1);
    check("clr_pulse", {31'b0, error_pulse}, 32'd1);
    check("clr_bits", bit_count, 32'd0);
    check("clr_errs", error_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
